// File: rtl/vproc_result_store.sv
// Result-side write sequencer: steps a store job through its EMUL register group,
// packing narrow half-width beat pairs, and drives one registered VRF write port.
module vproc_result_store #(
  parameter  int unsigned VREG_W    = 128,
  localparam int unsigned VREG_BE_W = VREG_W / 8
) (
  input  logic                 clk_i,
  input  logic                 sync_rst_ni,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [4:0]           job_base_i,
  input  logic [1:0]           job_emul_i,
  input  logic                 job_narrow_i,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [VREG_W-1:0]    res_data_i,
  input  logic [VREG_BE_W-1:0] res_be_i,
  output logic                 vreg_wr_en_o,
  output logic [4:0]           vreg_wr_addr_o,
  output logic [VREG_BE_W-1:0] vreg_wr_be_o,
  output logic [VREG_W-1:0]    vreg_wr_o,
  output logic [31:0]          clear_hazard_o,
  output logic                 done_o
);

  localparam int unsigned HALF_W    = VREG_W / 2;
  localparam int unsigned HALF_BE_W = VREG_BE_W / 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STORE = 1'b1
  } state_e;

  state_e                 state_r, state_s;
  logic [4:0]             base_r;
  logic [1:0]             emul_r;
  logic                   narrow_r;
  logic [2:0]             reg_idx_r;
  logic                   half_r;
  logic [HALF_W-1:0]      hold_data_r;
  logic [HALF_BE_W-1:0]   hold_be_r;

  logic [2:0]             last_idx_s;
  logic                   beat_fire_s;
  logic                   write_s;
  logic                   final_s;
  logic                   job_fire_s;
  logic [4:0]             wr_addr_s;
  logic [VREG_W-1:0]      wr_data_s;
  logic [VREG_BE_W-1:0]   wr_be_s;

  // Index of the last register in the group (G-1).
  always_comb begin
    case (emul_r)
      2'd0:    last_idx_s = 3'd0;
      2'd1:    last_idx_s = 3'd1;
      2'd2:    last_idx_s = 3'd3;
      2'd3:    last_idx_s = 3'd7;
      default: last_idx_s = 3'd0;
    endcase
  end

  // Beat handshake decode and write data assembly.
  always_comb begin
    beat_fire_s = (state_r == STORE) && res_valid_i;
    write_s     = beat_fire_s && (!narrow_r || half_r);
    final_s     = write_s && (reg_idx_r == last_idx_s);
    job_fire_s  = job_valid_i && job_ready_o;
    // OR rather than add: a misaligned base aliases inside its group.
    wr_addr_s   = base_r | {2'b00, reg_idx_r};
    if (narrow_r) begin
      wr_data_s = {res_data_i[HALF_W-1:0], hold_data_r};
      wr_be_s   = {res_be_i[HALF_BE_W-1:0], hold_be_r};
    end else begin
      wr_data_s = res_data_i;
      wr_be_s   = res_be_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a job offered on the final beat re-enters STORE directly.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (job_fire_s) begin
          state_s = STORE;
        end else begin
          state_s = IDLE;
        end
      end
      STORE: begin
        if (final_s) begin
          state_s = job_valid_i ? STORE : IDLE;
        end else begin
          state_s = STORE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs, decoded from state.
  always_comb begin
    job_ready_o = 1'b0;
    res_ready_o = 1'b0;
    case (state_r)
      IDLE: begin
        job_ready_o = 1'b1;
        res_ready_o = 1'b0;
      end
      STORE: begin
        job_ready_o = final_s;
        res_ready_o = 1'b1;
      end
      default: begin
        job_ready_o = 1'b1;
        res_ready_o = 1'b0;
      end
    endcase
  end

  // Job context, group index and narrow holding register.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      base_r      <= 5'd0;
      emul_r      <= 2'd0;
      narrow_r    <= 1'b0;
      reg_idx_r   <= 3'd0;
      half_r      <= 1'b0;
      hold_data_r <= '0;
      hold_be_r   <= '0;
    end else if (job_fire_s) begin
      base_r      <= job_base_i;
      emul_r      <= job_emul_i;
      narrow_r    <= job_narrow_i;
      reg_idx_r   <= 3'd0;
      half_r      <= 1'b0;
      hold_data_r <= '0;
      hold_be_r   <= '0;
    end else if (beat_fire_s) begin
      if (narrow_r && !half_r) begin
        hold_data_r <= res_data_i[HALF_W-1:0];
        hold_be_r   <= res_be_i[HALF_BE_W-1:0];
        half_r      <= 1'b1;
      end else begin
        half_r    <= 1'b0;
        reg_idx_r <= reg_idx_r + 3'd1;
      end
    end
  end

  // Registered VRF write port, hazard clear and completion pulse.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      vreg_wr_en_o   <= 1'b0;
      vreg_wr_addr_o <= 5'd0;
      vreg_wr_be_o   <= '0;
      vreg_wr_o      <= '0;
      clear_hazard_o <= 32'd0;
      done_o         <= 1'b0;
    end else begin
      vreg_wr_en_o <= write_s;
      done_o       <= final_s;
      if (write_s) begin
        vreg_wr_addr_o <= wr_addr_s;
        vreg_wr_be_o   <= wr_be_s;
        vreg_wr_o      <= wr_data_s;
        clear_hazard_o <= 32'd1 << wr_addr_s;
      end else begin
        clear_hazard_o <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_vproc_result_store.sv
// Directed self-checking bench for vproc_result_store (VREG_W=128).
module tb_vproc_result_store;

  localparam int VREG_W    = 128;
  localparam int VREG_BE_W = VREG_W / 8;

  logic                 clk_i = 1'b0;
  logic                 sync_rst_ni;
  logic                 job_valid_i;
  logic                 job_ready_o;
  logic [4:0]           job_base_i;
  logic [1:0]           job_emul_i;
  logic                 job_narrow_i;
  logic                 res_valid_i;
  logic                 res_ready_o;
  logic [VREG_W-1:0]    res_data_i;
  logic [VREG_BE_W-1:0] res_be_i;
  logic                 vreg_wr_en_o;
  logic [4:0]           vreg_wr_addr_o;
  logic [VREG_BE_W-1:0] vreg_wr_be_o;
  logic [VREG_W-1:0]    vreg_wr_o;
  logic [31:0]          clear_hazard_o;
  logic                 done_o;

  int tests_run    = 0;
  int tests_failed = 0;

  vproc_result_store #(.VREG_W(VREG_W)) dut (
    .clk_i          (clk_i),
    .sync_rst_ni    (sync_rst_ni),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_base_i     (job_base_i),
    .job_emul_i     (job_emul_i),
    .job_narrow_i   (job_narrow_i),
    .res_valid_i    (res_valid_i),
    .res_ready_o    (res_ready_o),
    .res_data_i     (res_data_i),
    .res_be_i       (res_be_i),
    .vreg_wr_en_o   (vreg_wr_en_o),
    .vreg_wr_addr_o (vreg_wr_addr_o),
    .vreg_wr_be_o   (vreg_wr_be_o),
    .vreg_wr_o      (vreg_wr_o),
    .clear_hazard_o (clear_hazard_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic [4:0] base, input logic [1:0] emul, input logic narrow);
    job_valid_i  = 1'b1;
    job_base_i   = base;
    job_emul_i   = emul;
    job_narrow_i = narrow;
    tick();
    job_valid_i  = 1'b0;
  endtask

  task automatic send_beat(input logic [VREG_W-1:0] data, input logic [VREG_BE_W-1:0] be);
    res_valid_i = 1'b1;
    res_data_i  = data;
    res_be_i    = be;
    tick();
    res_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst_ni = 1'b0;
    tick();
    tick();
    tests_run++;
    if (job_ready_o !== 1'b1 || res_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got job=%b res=%b expected job=1 res=0", job_ready_o, res_ready_o);
    end
    tests_run++;
    if (vreg_wr_en_o !== 1'b0 || vreg_wr_addr_o !== 5'd0 || vreg_wr_be_o !== 16'h0 ||
        vreg_wr_o !== 128'h0 || clear_hazard_o !== 32'h0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b addr=%0d be=%h data=%h hz=%h done=%b expected all zero",
               vreg_wr_en_o, vreg_wr_addr_o, vreg_wr_be_o, vreg_wr_o, clear_hazard_o, done_o);
    end
    sync_rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    start_job(5'd5, 2'd0, 1'b0);
    send_beat(d, 16'hFFFF);
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd5 || vreg_wr_o !== d ||
        vreg_wr_be_o !== 16'hFFFF || clear_hazard_o !== 32'h20 || done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h be=%h hz=%h done=%b expected 1/5/%h/ffff/20/1",
               vreg_wr_en_o, vreg_wr_addr_o, vreg_wr_o, vreg_wr_be_o, clear_hazard_o, done_o, d);
    end
    tick();
    tests_run++;
    if (vreg_wr_en_o !== 1'b0 || clear_hazard_o !== 32'h0 || done_o !== 1'b0 || job_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_after: got en=%b hz=%h done=%b jrdy=%b expected 0/0/0/1",
               vreg_wr_en_o, clear_hazard_o, done_o, job_ready_o);
    end
  endtask

  task automatic test_gaps();
    int gaps [4] = '{0, 0, 2, 1};
    logic [127:0] d;
    start_job(5'd8, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        tests_run++;
        if (vreg_wr_en_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL gap_idle%0d: got wr_en=%b expected 0", i, vreg_wr_en_o);
        end
      end
      d = {4{32'hC0DE_0000 + 32'(i)}};
      send_beat(d, 16'hF0F0);
      tests_run++;
      if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'(8 + i) || vreg_wr_o !== d ||
          clear_hazard_o !== (32'd1 << (8 + i)) || done_o !== (i == 3)) begin
        tests_failed++;
        $display("FAIL gap_write%0d: got en=%b addr=%0d hz=%h done=%b expected 1/%0d/%h/%b",
                 i, vreg_wr_en_o, vreg_wr_addr_o, clear_hazard_o, done_o, 8 + i,
                 32'd1 << (8 + i), i == 3);
      end
    end
    tick();
  endtask

  task automatic test_narrow();
    logic [127:0] a, b, c, d, exp;
    logic [15:0]  exp_be;
    a = 128'h1111_2222_3333_4444_A0A1_A2A3_A4A5_A6A7;
    b = 128'h5555_6666_7777_8888_B0B1_B2B3_B4B5_B6B7;
    c = 128'h9999_AAAA_BBBB_CCCC_C0C1_C2C3_C4C5_C6C7;
    d = 128'hDDDD_EEEE_FFFF_0000_D0D1_D2D3_D4D5_D6D7;
    start_job(5'd2, 2'd1, 1'b1);
    send_beat(a, 16'h00F3);
    tests_run++;
    if (vreg_wr_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_A: got wr_en=%b expected 0", vreg_wr_en_o);
    end
    send_beat(b, 16'hFF5A);
    exp    = {b[63:0], a[63:0]};
    exp_be = 16'h5AF3;
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd2 || vreg_wr_o !== exp ||
        vreg_wr_be_o !== exp_be || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_B: got en=%b addr=%0d data=%h be=%h done=%b expected 1/2/%h/%h/0",
               vreg_wr_en_o, vreg_wr_addr_o, vreg_wr_o, vreg_wr_be_o, done_o, exp, exp_be);
    end
    send_beat(c, 16'h0081);
    tests_run++;
    if (vreg_wr_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_C: got wr_en=%b expected 0", vreg_wr_en_o);
    end
    send_beat(d, 16'h003C);
    exp    = {d[63:0], c[63:0]};
    exp_be = 16'h3C81;
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd3 || vreg_wr_o !== exp ||
        vreg_wr_be_o !== exp_be || clear_hazard_o !== 32'h8 || done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL narrow_D: got en=%b addr=%0d data=%h be=%h done=%b expected 1/3/%h/%h/1",
               vreg_wr_en_o, vreg_wr_addr_o, vreg_wr_o, vreg_wr_be_o, done_o, exp, exp_be);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start_job(5'd1, 2'd0, 1'b0);
    res_valid_i  = 1'b1;
    res_data_i   = {4{32'h0000_0B01}};
    res_be_i     = 16'hFFFF;
    job_valid_i  = 1'b1;
    job_base_i   = 5'd4;
    job_emul_i   = 2'd1;
    job_narrow_i = 1'b0;
    #1;
    tests_run++;
    if (job_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready_final: got job_ready=%b expected 1", job_ready_o);
    end
    tick();
    job_valid_i = 1'b0;
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd1 || done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_w0: got en=%b addr=%0d done=%b expected 1/1/1", vreg_wr_en_o, vreg_wr_addr_o, done_o);
    end
    res_data_i = {4{32'h0000_0B04}};
    tick();
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd4 || done_o !== 1'b0 ||
        vreg_wr_o !== {4{32'h0000_0B04}}) begin
      tests_failed++;
      $display("FAIL b2b_w1: got en=%b addr=%0d done=%b expected 1/4/0", vreg_wr_en_o, vreg_wr_addr_o, done_o);
    end
    tick();
    res_valid_i = 1'b0;
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd5 || done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_w2: got en=%b addr=%0d done=%b expected 1/5/1", vreg_wr_en_o, vreg_wr_addr_o, done_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_job();
    start_job(5'd16, 2'd2, 1'b0);
    send_beat({4{32'h1600_0000}}, 16'hFFFF);
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd16) begin
      tests_failed++;
      $display("FAIL rst_first: got en=%b addr=%0d expected 1/16", vreg_wr_en_o, vreg_wr_addr_o);
    end
    sync_rst_ni = 1'b0;
    send_beat({4{32'h1600_0001}}, 16'hFFFF);
    sync_rst_ni = 1'b1;
    tests_run++;
    if (vreg_wr_en_o !== 1'b0 || clear_hazard_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_suppress: got en=%b hz=%h expected 0/0", vreg_wr_en_o, clear_hazard_o);
    end
    tests_run++;
    if (job_ready_o !== 1'b1 || res_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_idle: got job=%b res=%b expected 1/0", job_ready_o, res_ready_o);
    end
    start_job(5'd16, 2'd1, 1'b0);
    send_beat({4{32'h1600_0002}}, 16'hFFFF);
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd16 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_newjob0: got en=%b addr=%0d done=%b expected 1/16/0", vreg_wr_en_o, vreg_wr_addr_o, done_o);
    end
    send_beat({4{32'h1600_0003}}, 16'hFFFF);
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd17 || done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_newjob1: got en=%b addr=%0d done=%b expected 1/17/1", vreg_wr_en_o, vreg_wr_addr_o, done_o);
    end
    tick();
  endtask

  task automatic test_misaligned();
    start_job(5'd3, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_beat({4{32'h0300_0000 + 32'(i)}}, 16'h0F0F);
      tests_run++;
      if (vreg_wr_en_o !== 1'b1 || vreg_wr_addr_o !== 5'd3 || clear_hazard_o !== 32'h8 || done_o !== (i == 1)) begin
        tests_failed++;
        $display("FAIL misaligned%0d: got en=%b addr=%0d hz=%h done=%b expected 1/3/8/%b",
                 i, vreg_wr_en_o, vreg_wr_addr_o, clear_hazard_o, done_o, i == 1);
      end
    end
    tick();
  endtask

  task automatic test_idle_beat_and_zero_be();
    res_valid_i = 1'b1;
    res_data_i  = {4{32'hBAD0_BAD0}};
    res_be_i    = 16'hFFFF;
    #1;
    tests_run++;
    if (res_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_res_ready: got %b expected 0", res_ready_o);
    end
    tick();
    res_valid_i = 1'b0;
    tests_run++;
    if (vreg_wr_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_beat: got wr_en=%b expected 0", vreg_wr_en_o);
    end
    start_job(5'd7, 2'd0, 1'b0);
    send_beat({4{32'h0700_0707}}, 16'h0000);
    tests_run++;
    if (vreg_wr_en_o !== 1'b1 || vreg_wr_be_o !== 16'h0 || clear_hazard_o !== 32'h80 ||
        vreg_wr_o !== {4{32'h0700_0707}} || done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_be: got en=%b be=%h hz=%h data=%h done=%b expected 1/0/80/07000707x4/1",
               vreg_wr_en_o, vreg_wr_be_o, clear_hazard_o, vreg_wr_o, done_o);
    end
    tick();
  endtask

  initial begin
    sync_rst_ni  = 1'b0;
    job_valid_i  = 1'b0;
    job_base_i   = 5'd0;
    job_emul_i   = 2'd0;
    job_narrow_i = 1'b0;
    res_valid_i  = 1'b0;
    res_data_i   = '0;
    res_be_i     = '0;
    test_reset();
    test_single();
    test_gaps();
    test_narrow();
    test_back_to_back();
    test_reset_mid_job();
    test_misaligned();
    test_idle_beat_and_zero_be();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
